// File: rtl/i2s_rx_deframer_if.sv
// rtl/i2s_rx_deframer_if.sv - I2S pin input and deframed sample bus
// Purpose: bundles the raw I2S pins and the sample/status outputs of the deframer.
// Signals:
//   i2s_in       {bck, lrck, data}, asynchronous to clk
//   sample_l/r   32-bit MSB-justified samples, held between pulses
//   sample_valid 1-clk pulse marking a new pair
//   bitnum       measured width code (0: 16, 1: 24, 2: 32 bits)
//   locked       format stable
//   fmt_err      1-clk pulse on a width mismatch or unsupported width
// Modports: master = deframer (sample producer), slave = pin driver / sample consumer.
interface i2s_rx_deframer_if;
  logic [2:0]  i2s_in;
  logic [31:0] sample_l;
  logic [31:0] sample_r;
  logic        sample_valid;
  logic [1:0]  bitnum;
  logic        locked;
  logic        fmt_err;

  modport master (
    input  i2s_in,
    output sample_l, sample_r, sample_valid, bitnum, locked, fmt_err
  );

  modport slave (
    output i2s_in,
    input  sample_l, sample_r, sample_valid, bitnum, locked, fmt_err
  );
endinterface

// File: rtl/i2s_rx_deframer.sv
// rtl/i2s_rx_deframer.sv - I2S receiver: synchronise, deframe, measure width, lock
// Purpose: receives an I2S stream asynchronous to clk, deframes it into left/right
//   sample pairs, measures bits per channel and reports lock once the width is stable.
// Ports:
//   clk  in  system/master clock (>= 4x BCK), rising edge
//   rst  in  asynchronous active-high reset
//   bus  i2s_rx_deframer_if.master: i2s_in in; sample_l, sample_r, sample_valid,
//        bitnum, locked, fmt_err out
module i2s_rx_deframer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  i2s_rx_deframer_if.master  bus
);

  localparam logic [1:0] BITNUM_B16 = 2'd0;
  localparam logic [1:0] BITNUM_B24 = 2'd1;
  localparam logic [1:0] BITNUM_B32 = 2'd2;
  localparam logic [1:0] BITNUM_BAD = 2'd3;
  localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {SEEK, ACQ, LOCK} state_e;

  // Index 0 is the stage nearest the pins; the last stage feeds the logic.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic          bck_prev_q, bck_prev_d;
  // The detected event and the bits sampled with it are registered once, so all
  // deframing runs one clk after the event clk.
  logic          evt_q, evt_d;
  logic          data_ev_q, data_ev_d;
  logic          lrck_ev_q, lrck_ev_d;
  logic [31:0]   sreg_q, sreg_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic          lrck_prev_q, lrck_prev_d;
  logic [31:0]   l_hold_q, l_hold_d;
  state_e        state_q, state_d;
  logic          acq_have_q, acq_have_d;
  logic [5:0]    acq_n_q, acq_n_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   sample_l_q, sample_l_d;
  logic [31:0]   sample_r_q, sample_r_d;
  logic          sample_valid_q, sample_valid_d;
  logic [1:0]    bitnum_q, bitnum_d;
  logic          locked_q, locked_d;
  logic          fmt_err_q, fmt_err_d;

  logic [31:0]   sreg_next;
  logic [31:0]   word;
  logic [5:0]    n;
  logic [5:0]    shamt;
  logic [1:0]    n_enc;
  logic          closed;
  logic          timeout;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.i2s_in};
    bck_prev_d = sync_q[SYNC_STAGES-1][2];
    evt_d      = sync_q[SYNC_STAGES-1][2] & ~bck_prev_q;
    lrck_ev_d  = sync_q[SYNC_STAGES-1][1];
    data_ev_d  = sync_q[SYNC_STAGES-1][0];

    sreg_next = {sreg_q[30:0], data_ev_q};
    closed    = evt_q && (lrck_ev_q != lrck_prev_q);
    // n counts the bit shifted in on this event, saturating at 63.
    n         = (bitcnt_q == 6'd63) ? 6'd63 : bitcnt_q + 6'd1;
    shamt     = (n >= 6'd32) ? 6'd0 : 6'd32 - n;
    word      = sreg_next << shamt;
    case (n)
      6'd16:   n_enc = BITNUM_B16;
      6'd24:   n_enc = BITNUM_B24;
      6'd32:   n_enc = BITNUM_B32;
      default: n_enc = BITNUM_BAD;
    endcase
    timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    sreg_d         = sreg_q;
    bitcnt_d       = bitcnt_q;
    lrck_prev_d    = lrck_prev_q;
    l_hold_d       = l_hold_q;
    state_d        = state_q;
    acq_have_d     = acq_have_q;
    acq_n_d        = acq_n_q;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    sample_valid_d = 1'b0;
    bitnum_d       = bitnum_q;
    locked_d       = locked_q;
    fmt_err_d      = 1'b0;

    // Counter parks at the limit so the timeout stays asserted until BCK returns.
    if (evt_q)        tcnt_d = '0;
    else if (timeout) tcnt_d = tcnt_q;
    else              tcnt_d = tcnt_q + TW'(1);

    if (evt_q) begin
      sreg_d   = sreg_next;
      bitcnt_d = closed ? 6'd0 : n;
      if (closed) begin
        lrck_prev_d = lrck_ev_q;
        if (lrck_ev_q) l_hold_d = word;
      end
    end

    if (timeout) begin
      state_d    = SEEK;
      locked_d   = 1'b0;
      acq_have_d = 1'b0;
    end else if (closed) begin
      case (state_q)
        SEEK: begin
          // lrck fell: a left word starts; the word just closed is a partial one.
          if (!lrck_ev_q) begin
            state_d    = ACQ;
            acq_have_d = 1'b0;
          end
        end
        ACQ: begin
          if (n_enc == BITNUM_BAD) begin
            fmt_err_d  = 1'b1;
            acq_have_d = 1'b0;
          end else if (acq_have_q && (n == acq_n_q)) begin
            state_d  = LOCK;
            locked_d = 1'b1;
            bitnum_d = n_enc;
          end else begin
            // A mismatch restarts the comparison from the current word.
            fmt_err_d  = acq_have_q;
            acq_have_d = 1'b1;
            acq_n_d    = n;
          end
        end
        LOCK: begin
          if (n_enc != bitnum_q) begin
            fmt_err_d  = 1'b1;
            locked_d   = 1'b0;
            state_d    = ACQ;
            acq_have_d = 1'b0;
          end else if (!lrck_ev_q) begin
            sample_l_d     = l_hold_q;
            sample_r_d     = word;
            sample_valid_d = 1'b1;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q         <= '0;
      bck_prev_q     <= 1'b0;
      evt_q          <= 1'b0;
      data_ev_q      <= 1'b0;
      lrck_ev_q      <= 1'b0;
      sreg_q         <= '0;
      bitcnt_q       <= '0;
      lrck_prev_q    <= 1'b0;
      l_hold_q       <= '0;
      state_q        <= SEEK;
      acq_have_q     <= 1'b0;
      acq_n_q        <= '0;
      tcnt_q         <= '0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      bitnum_q       <= BITNUM_B16;
      locked_q       <= 1'b0;
      fmt_err_q      <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      bck_prev_q     <= bck_prev_d;
      evt_q          <= evt_d;
      data_ev_q      <= data_ev_d;
      lrck_ev_q      <= lrck_ev_d;
      sreg_q         <= sreg_d;
      bitcnt_q       <= bitcnt_d;
      lrck_prev_q    <= lrck_prev_d;
      l_hold_q       <= l_hold_d;
      state_q        <= state_d;
      acq_have_q     <= acq_have_d;
      acq_n_q        <= acq_n_d;
      tcnt_q         <= tcnt_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
      bitnum_q       <= bitnum_d;
      locked_q       <= locked_d;
      fmt_err_q      <= fmt_err_d;
    end
  end

  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.bitnum       = bitnum_q;
  assign bus.locked       = locked_q;
  assign bus.fmt_err      = fmt_err_q;

endmodule

// File: tb/tb_i2s_rx_deframer.sv
// tb/tb_i2s_rx_deframer.sv - scoreboard bench for i2s_rx_deframer
module tb_i2s_rx_deframer;
  localparam int SYNC = 2;
  localparam int TMO  = 256;
  localparam int M_SEEK = 0, M_ACQ = 1, M_LOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  i2s_rx_deframer_if bus();

  i2s_rx_deframer #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          at;
    logic [1:0]  bn;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  int          last_rise = 0;

  // Word-level reference: each completed word is judged by its length only.
  int          m_st = M_SEEK;
  bit          m_have = 0;
  int          m_prev = 0;
  int          m_width = 16;
  int          m_err = 0;
  logic [31:0] m_lhold = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] enc(int w);
    return (w == 16) ? 2'd0 : (w == 24) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [31:0] rmask(int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic void model_reset();
    m_st = M_SEEK; m_have = 0; m_prev = 0; m_width = 16; m_err = 0; m_lhold = '0;
  endfunction

  function automatic void model_word(int n, logic [31:0] v, bit left, int stamp);
    logic [31:0] w;
    bit ok;
    exp_t e;
    w  = v << (32 - n);
    ok = (n == 16) || (n == 24) || (n == 32);
    if (left) m_lhold = w;
    case (m_st)
      M_SEEK: if (!left) begin m_st = M_ACQ; m_have = 0; end
      M_ACQ: begin
        if (!ok) begin m_err++; m_have = 0; end
        else if (m_have && n == m_prev) begin m_st = M_LOCK; m_width = n; end
        else begin if (m_have) m_err++; m_have = 1; m_prev = n; end
      end
      default: begin
        if (n != m_width) begin m_err++; m_st = M_ACQ; m_have = 0; end
        else if (!left) begin
          e.l = m_lhold; e.r = w; e.at = stamp + SYNC + 2; e.bn = enc(m_width);
          exp_q.push_back(e);
        end
      end
    endcase
  endfunction

  // One BCK period = 8 clk; lrck/data change with the falling edge.
  task automatic drive_slot(bit lr, bit d, output int stamp);
    @(negedge clk);
    bus.i2s_in = {1'b0, lr, d};
    repeat (4) @(negedge clk);
    bus.i2s_in[2] = 1'b1;
    stamp = cyc;
    last_rise = cyc;
    repeat (3) @(negedge clk);
  endtask

  // lrck already shows the next channel during the LSB slot.
  task automatic play_word(int n, logic [31:0] v, bit left);
    int st;
    for (int j = n - 1; j >= 0; j--)
      drive_slot((j == 0) ? left : ~left, v[j], st);
    model_word(n, v, left, st);
  endtask

  task automatic play_frame(int wl, logic [31:0] l, int wr, logic [31:0] r);
    play_word(wl, l, 1'b1);
    play_word(wr, r, 1'b0);
  endtask

  // w == 0 picks a random supported width per frame.
  task automatic play_rand(int count, int w);
    int ww;
    for (int i = 0; i < count; i++) begin
      ww = w;
      if (w == 0) ww = 8 * $urandom_range(2, 4);
      play_frame(ww, $urandom & rmask(ww), ww, $urandom & rmask(ww));
    end
  endtask

  task automatic checkpoint(string tag);
    repeat (10) @(negedge clk);
    check({tag, "_locked"}, bus.locked, (m_st == M_LOCK));
    check({tag, "_fmt_err_count"}, err_seen, m_err);
    check({tag, "_pending_pairs"}, exp_q.size(), 0);
    if (m_st == M_LOCK) check({tag, "_bitnum"}, bus.bitnum, enc(m_width));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_sample_l"}, bus.sample_l, 0);
    check({tag, "_sample_r"}, bus.sample_r, 0);
    check({tag, "_sample_valid"}, bus.sample_valid, 0);
    check({tag, "_bitnum"}, bus.bitnum, 0);
    check({tag, "_locked"}, bus.locked, 0);
    check({tag, "_fmt_err"}, bus.fmt_err, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fmt_err) err_seen++;
      if (bus.sample_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pair_l", bus.sample_l, e.l);
          check("pair_r", bus.sample_r, e.r);
          check("pair_latency", cyc, e.at);
          check("pair_bitnum", bus.bitnum, e.bn);
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dt;
    bus.i2s_in = 3'b000;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) play_frame(24, 32'hABCDEF, 24, 32'h123456);
    checkpoint("b24");
    check("b24_fixed_locked", bus.locked, 1);
    check("b24_fixed_bitnum", bus.bitnum, 2'd1);
    check("b24_fixed_l", bus.sample_l, 32'hABCDEF00);
    check("b24_fixed_r", bus.sample_r, 32'h12345600);

    for (int i = 0; i < 5; i++) play_frame(16, 32'h8001, 16, 32'h7FFF);
    checkpoint("b16");
    check("b16_fixed_l", bus.sample_l, 32'h80010000);
    check("b16_fixed_r", bus.sample_r, 32'h7FFF0000);
    play_rand(3, 16);
    checkpoint("b16_rand");

    play_rand(4, 32);
    checkpoint("b32");
    play_rand(4, 24);
    checkpoint("b32_to_b24");

    play_rand(4, 20);
    checkpoint("b20");
    check("b20_locked", bus.locked, 0);

    play_rand(12, 0);
    checkpoint("mixed");

    play_rand(4, 24);
    checkpoint("pre_timeout");
    t0 = last_rise;
    dt = -1;
    for (int i = 0; i < TMO + 64; i++) begin
      @(negedge clk);
      if (!bus.locked) begin dt = cyc - t0; break; end
    end
    check("timeout_window", (dt >= TMO + SYNC + 1) && (dt <= TMO + SYNC + 2), 1);
    model_timeout_step();
    checkpoint("timeout");
    play_rand(5, 24);
    checkpoint("relock");

    play_rand(3, 24);
    for (int i = 0; i < 10; i++) begin
      int st;
      drive_slot(1'b0, 1'($urandom), st);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midword_reset");
    exp_q.delete();
    err_seen = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    play_rand(5, 24);
    checkpoint("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic void model_timeout_step();
    m_st = M_SEEK;
    m_have = 0;
  endfunction

endmodule
